// File: rtl/data_memory_pipelined.sv
// Byte-addressable big-endian data memory with registered 1-cycle response.
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module data_memory_pipelined #(
  parameter int          DEPTH_BYTES = 1024,
  parameter int          ADDR_WIDTH  = 32,
  parameter logic [31:0] INIT_VALUE  = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_width,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic                  init_busy
);

  localparam int LG    = $clog2(DEPTH_BYTES);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int IW    = (LG > 2) ? LG - 2 : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [31:0]   mem_q [WORDS];

  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_error_q, rsp_error_d;

  logic [IW-1:0] idx;
  logic          oob;
  logic          acc;
  logic          bad;
  logic          st_we;
  logic [1:0]    off;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   rd_word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   ld_val;

  generate
    if (LG > 2) begin : g_idx
      assign idx = req_addr[LG-1:2];
    end else begin : g_idx0
      assign idx = '0;
    end
    if (ADDR_WIDTH > LG) begin : g_oob
      assign oob = |req_addr[ADDR_WIDTH-1:LG];
    end else begin : g_nooob
      assign oob = 1'b0;
    end
  endgenerate

  // State register: init sequencer and run mode
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: walk every word once, then run
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == S_INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == LAST) begin
        state_d = S_RUN;
        ptr_d   = '0;
      end
    end
  end

  // Handshake outputs, forced quiet while reset is held
  always_comb begin
    req_ready = !reset && (state_q == S_RUN);
    init_busy = reset || (state_q != S_RUN);
  end

  // Access decode: alignment, lanes, errors and load extraction
  always_comb begin
    acc = req_valid && req_ready;
    off = req_addr[1:0];
    bad = (req_width == 2'b11) || oob;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (req_width == 2'b01 && req_addr[0])
      bad = 1'b1;
    if (req_width == 2'b10 && req_addr[1:0] != 2'b00)
      bad = 1'b1;
`endif
    if (req_width == 2'b01)
      off = {req_addr[1], 1'b0};
    else if (req_width == 2'b10)
      off = 2'b00;

    be = 4'b0000;
    wd = req_wdata;
    unique case (req_width)
      2'b00: begin
        be = 4'b1000 >> off;
        wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be = off[1] ? 4'b0011 : 4'b1100;
        wd = {2{req_wdata[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    st_we = acc && req_write && !bad;

    rd_word = mem_q[idx];
    byte_v  = 8'(rd_word >> {~off, 3'b000});
    half_v  = off[1] ? rd_word[15:0] : rd_word[31:16];
    unique case (req_width)
      2'b00:   ld_val = {{24{req_signed & byte_v[7]}}, byte_v};
      2'b01:   ld_val = {{16{req_signed & half_v[15]}}, half_v};
      default: ld_val = rd_word;
    endcase

    rsp_valid_d = acc;
    rsp_error_d = acc && bad;
    rsp_rdata_d = (acc && !req_write && !bad) ? ld_val : 32'h0;
  end

  // Storage: init fill, then lane-enabled stores
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == S_INIT) begin
        mem_q[ptr_q] <= INIT_VALUE;
      end else if (st_we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i])
            mem_q[idx][8*i +: 8] <= wd[8*i +: 8];
        end
      end
    end
  end

  // Response register, one pulse per accepted request
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // A reset arriving after acceptance swallows the pending response
  always_comb begin
    rsp_valid = rsp_valid_q && !reset;
    rsp_rdata = reset ? 32'h0 : rsp_rdata_q;
    rsp_error = rsp_error_q && !reset;
  end

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Directed table-driven bench for data_memory_pipelined.
// Expected values follow the misalign trap build option.
module tb_data_memory_pipelined;

  localparam logic [31:0] IV = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_width;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        init_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  w;
    logic        s;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  data_memory_pipelined #(
    .DEPTH_BYTES(1024),
    .ADDR_WIDTH(32),
    .INIT_VALUE(IV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_width(req_width),
    .req_signed(req_signed),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] w,
                              input logic s, input logic [31:0] a,
                              input logic [31:0] wd,
                              input logic [31:0] rd, input logic er);
    vec_t v;
    v.wr = wr; v.w = w; v.s = s; v.a = a;
    v.wd = wd; v.rd = rd; v.er = er;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_width  = v.w;
    req_signed = v.s;
    req_addr   = v.a;
    req_wdata  = v.wd;
  endtask

  task automatic wait_init(input string nm);
    int n;
    n = 0;
    while (init_busy && n < 2000) begin
      chk({nm, "_ready_low"}, {31'h0, req_ready}, 32'h0);
      n++;
      @(negedge clk);
    end
    chk({nm, "_cycles"}, n, 256);
    chk({nm, "_ready_high"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_width = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;

    vecs.push_back(mk(0, 2'b10, 0, 32'h3FC, 0, IV, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h010, 32'h11223344, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h010, 0, 32'h11, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h013, 0, 32'h44, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h012, 0, 32'h3344, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h012, 0, 32'h33, 0));
    vecs.push_back(mk(0, 2'b10, 1, 32'h010, 0, 32'h11223344, 0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h021, 32'h5A5A5AAB, 0, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h021, 0, 32'hFFFFFFAB, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h021, 0, 32'h000000AB, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h020, 0, 32'hDEABBEEF, 0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h022, 32'h12348001, 0, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h022, 0, 32'hFFFF8001, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h020, 0, 32'h0000DEAB, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h020, 0, 32'hFFFFDEAB, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h400, 32'h99999999, 0, 1));
    vecs.push_back(mk(0, 2'b11, 0, 32'h010, 0, 0, 1));
    vecs.push_back(mk(0, 2'b00, 0, 32'h400, 0, 0, 1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h80000000, 0, 0, 1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h000, 0, IV, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h010, 0, 32'h11223344, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h3FF, 0, 32'hEF, 0));
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, 2'b01, 0, 32'h011, 0, 0, 1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h013, 0, 0, 1));
    vecs.push_back(mk(1, 2'b01, 0, 32'h021, 32'h5566, 0, 1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h020, 0, 32'hDEAB8001, 0));
`else
    vecs.push_back(mk(0, 2'b01, 0, 32'h011, 0, 32'h1122, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h013, 0, 32'h11223344, 0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h021, 32'h5566, 0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h020, 0, 32'h55668001, 0));
`endif

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_busy", {31'h0, init_busy}, 32'h1);
    chk("rst_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_error", {31'h0, rsp_error}, 32'h0);
    reset = 1'b0;
    wait_init("init");

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), {31'h0, rsp_valid}, 32'h1);
      chk($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].rd);
      chk($sformatf("v%0d_error", i), {31'h0, rsp_error}, {31'h0, vecs[i].er});
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), {31'h0, rsp_valid}, 32'h0);
      chk($sformatf("v%0d_idle_rd", i), rsp_rdata, 32'h0);
    end

    drive(mk(1, 2'b10, 0, 32'h040, 32'hCAFEF00D, 0, 0));
    @(posedge clk);
    #1 drive(mk(0, 2'b10, 0, 32'h040, 0, 0, 0));
    @(negedge clk);
    chk("b2b_st_valid", {31'h0, rsp_valid}, 32'h1);
    chk("b2b_st_rdata", rsp_rdata, 32'h0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_ld_valid", {31'h0, rsp_valid}, 32'h1);
    chk("b2b_ld_rdata", rsp_rdata, 32'hCAFEF00D);
    @(negedge clk);
    chk("b2b_idle", {31'h0, rsp_valid}, 32'h0);

    drive(mk(0, 2'b10, 0, 32'h040, 0, 0, 0));
    @(posedge clk);
    #1 begin
      req_valid = 1'b0;
      reset = 1'b1;
    end
    @(negedge clk);
    chk("mid_rst_valid", {31'h0, rsp_valid}, 32'h0);
    chk("mid_rst_rdata", rsp_rdata, 32'h0);
    chk("mid_rst_busy", {31'h0, init_busy}, 32'h1);
    chk("mid_rst_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    chk("mid_rst_valid2", {31'h0, rsp_valid}, 32'h0);
    reset = 1'b0;
    wait_init("reinit");

    drive(mk(0, 2'b10, 0, 32'h040, 0, 0, 0));
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("reinit_valid", {31'h0, rsp_valid}, 32'h1);
    chk("reinit_rdata", rsp_rdata, IV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
